// File: rtl/alu_share_ctrl_pkg.sv
// Shared opcodes, FSM encoding and opcode legality for the two-requester ALU front end.
package alu_share_ctrl_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers the last accepted index.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    input  logic       accept_idx,
    output logic [1:0] grant
);

    logic last;

    // Reset to 1 so that requester 0 wins the first contended cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= accept_idx;
        end
    end

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one external ALU and returns a tagged response
// one cycle after acceptance, under a valid/ready handshake.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic [DATA_WIDTH-1:0] m0_a,
    input  logic [DATA_WIDTH-1:0] m0_b,
    input  logic [2:0]            m0_op,
    input  logic [TAG_WIDTH-1:0]  m0_tag,
    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic [DATA_WIDTH-1:0] m1_a,
    input  logic [DATA_WIDTH-1:0] m1_b,
    input  logic [2:0]            m1_op,
    input  logic [TAG_WIDTH-1:0]  m1_tag,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [2:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_Result,
    input  logic                  alu_Overflow,
    input  logic                  alu_CarryOut,
    input  logic                  alu_Zero,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic                  resp_overflow,
    output logic                  resp_carryout,
    output logic                  resp_zero,
    output logic                  resp_err
);

    state_t                state;
    state_t                state_next;
    logic                  err;
    logic                  slot_free;
    logic [1:0]            grant;
    logic                  accept;
    logic                  accept_idx;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [2:0]            sel_op;
    logic [TAG_WIDTH-1:0]  sel_tag;

    assign resp_valid = (state == ST_HOLD);
    assign slot_free  = ~resp_valid | resp_ready;

    rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      ({m1_valid, m0_valid}),
        .accept     (accept),
        .accept_idx (accept_idx),
        .grant      (grant)
    );

    // Ready depends only on valids, the arbiter pointer and the response slot.
    assign m0_ready   = grant[0] & slot_free;
    assign m1_ready   = grant[1] & slot_free;
    assign accept     = (m0_valid & m0_ready) | (m1_valid & m1_ready);
    assign accept_idx = m1_ready;

    assign sel_a   = accept_idx ? m1_a   : m0_a;
    assign sel_b   = accept_idx ? m1_b   : m0_b;
    assign sel_op  = accept_idx ? m1_op  : m0_op;
    assign sel_tag = accept_idx ? m1_tag : m0_tag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_HOLD;
            ST_HOLD: if (resp_ready && !accept) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand registers only move on accept, so a stalled response stays stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_A    <= '0;
            alu_B    <= '0;
            alu_op   <= OP_AND;
            err      <= 1'b0;
            resp_id  <= 1'b0;
            resp_tag <= '0;
        end else if (accept) begin
            alu_A    <= sel_a;
            alu_B    <= sel_b;
            alu_op   <= op_legal(sel_op) ? sel_op : OP_AND;
            err      <= ~op_legal(sel_op);
            resp_id  <= accept_idx;
            resp_tag <= sel_tag;
        end
    end

    assign resp_result   = err ? '0 : alu_Result;
    assign resp_overflow = ~err & alu_Overflow;
    assign resp_carryout = ~err & alu_CarryOut;
    assign resp_zero     = ~err & alu_Zero;
    assign resp_err      = err;

endmodule
